// File: rtl/lap_capture_mux.sv
// Lap capture buffer and display selector for the stopwatch.
// Define LAP_OVERWRITE_EN to let laps taken when full replace the oldest entry.
module lap_capture_mux #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] Q0,
    input  logic [3:0] Q1,
    input  logic [3:0] Q2,
    input  logic [3:0] Q3,
    input  logic [3:0] Q4,
    input  logic [3:0] Q5,
    input  logic       lap,
    input  logic       view,
    input  logic       clr,
    output logic [3:0] D0,
    output logic [3:0] D1,
    output logic [3:0] D2,
    output logic [3:0] D3,
    output logic [3:0] D4,
    output logic [3:0] D5,
    output logic [3:0] D6,
    output logic [3:0] D7,
    output logic       full,
    output logic       ovf
);

    localparam logic [2:0] DEP  = 3'(DEPTH);
    localparam logic [2:0] LAST = 3'(DEPTH - 1);

    logic [23:0] mem [8];
    logic [2:0]  wp, rp, cnt, sel;
    logic [2:0]  wp_n, rp_n, cnt_n, sel_n;
    logic        ovf_n, wr_en;
    logic [23:0] live, frame;
    logic [3:0]  idx_sum;
    logic [2:0]  idx;
    logic [3:0]  d_q [8];
    logic [3:0]  d_n [8];

    function automatic logic [2:0] inc(input logic [2:0] p);
        return (p == LAST) ? 3'd0 : p + 3'd1;
    endfunction

    assign live = {Q5, Q4, Q3, Q2, Q1, Q0};

    always_comb begin
        wp_n  = wp;
        rp_n  = rp;
        cnt_n = cnt;
        sel_n = sel;
        ovf_n = ovf;
        wr_en = 1'b0;
        if (clr) begin
            wp_n  = 3'd0;
            rp_n  = 3'd0;
            cnt_n = 3'd0;
            sel_n = 3'd0;
            ovf_n = 1'b0;
        end else begin
            if (view)
                sel_n = (sel < cnt) ? sel + 3'd1 : 3'd0;
            if (lap) begin
                if (cnt != DEP) begin
                    wr_en = 1'b1;
                    wp_n  = inc(wp);
                    cnt_n = cnt + 3'd1;
                end else begin
                    ovf_n = 1'b1;
`ifdef LAP_OVERWRITE_EN
                    wr_en = 1'b1;
                    wp_n  = inc(wp);
                    rp_n  = inc(rp);
`else
                    wr_en = 1'b0;
`endif
                end
            end
        end
    end

    // Display follows post-edge state; same-edge captures bypass the memory.
    always_comb begin
        idx_sum = {1'b0, rp_n} + {1'b0, sel_n} - 4'd1;
        idx     = (idx_sum >= {1'b0, DEP}) ? 3'(idx_sum - {1'b0, DEP})
                                           : idx_sum[2:0];
        if (sel_n == 3'd0)
            frame = live;
        else if (wr_en && idx == wp)
            frame = live;
        else
            frame = mem[idx];
        for (int i = 0; i < 6; i++)
            d_n[i] = frame[4*i +: 4];
        d_n[6] = {1'b0, cnt_n};
        d_n[7] = {1'b0, sel_n};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp   <= 3'd0;
            rp   <= 3'd0;
            cnt  <= 3'd0;
            sel  <= 3'd0;
            ovf  <= 1'b0;
            full <= 1'b0;
            for (int i = 0; i < 8; i++)
                d_q[i] <= 4'd0;
        end else begin
            wp   <= wp_n;
            rp   <= rp_n;
            cnt  <= cnt_n;
            sel  <= sel_n;
            ovf  <= ovf_n;
            full <= (cnt_n == DEP);
            for (int i = 0; i < 8; i++)
                d_q[i] <= d_n[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_en)
            mem[wp] <= live;
    end

    assign D0 = d_q[0];
    assign D1 = d_q[1];
    assign D2 = d_q[2];
    assign D3 = d_q[3];
    assign D4 = d_q[4];
    assign D5 = d_q[5];
    assign D6 = d_q[6];
    assign D7 = d_q[7];

endmodule

// File: tb/tb_lap_capture_mux.sv
// Scoreboard bench for lap_capture_mux using a lap-list reference model.
// Honours LAP_OVERWRITE_EN the same way as the design.
module tb_lap_capture_mux;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        full;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] q = 24'h0;
    logic        lap = 1'b0, view = 1'b0, clr = 1'b0;
    logic [3:0]  d0, d1, d2, d3, d4, d5, d6, d7;
    logic        full, ovf;

    int          total = 0;
    int          bad = 0;
    exp_t        sb [$];
    logic [23:0] laps [$];
    int          m_sel = 0;
    logic        m_ovf = 1'b0;

    lap_capture_mux #(.DEPTH(DEPTH)) dut (
        .clk (clk),  .rstn(rstn),
        .Q0  (q[3:0]),   .Q1(q[7:4]),   .Q2(q[11:8]),
        .Q3  (q[15:12]), .Q4(q[19:16]), .Q5(q[23:20]),
        .lap (lap),  .view(view), .clr(clr),
        .D0  (d0), .D1(d1), .D2(d2), .D3(d3),
        .D4  (d4), .D5(d5), .D6(d6), .D7(d7),
        .full(full), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] bcd(input int t);
        logic [23:0] r;
        int v;
        v = t;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] rand_bcd();
        logic [23:0] r;
        for (int i = 0; i < 6; i++)
            r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic model_reset();
        laps.delete();
        m_sel = 0;
        m_ovf = 1'b0;
    endtask

    task automatic cycle(input logic l, input logic v, input logic c,
                         input logic [23:0] qv);
        exp_t e, g;
        int   pre;
        logic [23:0] shown;
        @(negedge clk);
        lap = l; view = v; clr = c; q = qv;
        if (c) begin
            model_reset();
        end else begin
            pre = laps.size();
            if (v) m_sel = (m_sel < pre) ? m_sel + 1 : 0;
            if (l) begin
                if (laps.size() < DEPTH) begin
                    laps.push_back(qv);
                end else begin
                    m_ovf = 1'b1;
`ifdef LAP_OVERWRITE_EN
                    void'(laps.pop_front());
                    laps.push_back(qv);
`endif
                end
            end
        end
        shown  = (m_sel == 0) ? qv : laps[m_sel-1];
        e.d    = {4'(m_sel), 4'(laps.size()), shown};
        e.full = (laps.size() == DEPTH);
        e.ovf  = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        lap = 1'b0; view = 1'b0; clr = 1'b0;
        g = sb.pop_front();
        chk("disp", {d7, d6, d5, d4, d3, d2, d1, d0}, g.d);
        chk("full", 32'(full), 32'(g.full));
        chk("ovf",  32'(ovf),  32'(g.ovf));
    endtask

    initial begin
        int t;
        #12;
        chk("rst_disp", {d7, d6, d5, d4, d3, d2, d1, d0}, 32'h0);
        chk("rst_flags", {30'h0, full, ovf}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();

        cycle(0, 0, 0, 24'h123456);
        cycle(0, 0, 0, 24'h123457);

        cycle(0, 0, 1, bcd(4));
        t = 5;
        cycle(1, 0, 0, bcd(t));
        for (t = 6; t < 9; t++) cycle(0, 0, 0, bcd(t));
        cycle(1, 0, 0, bcd(9));
        cycle(0, 1, 0, bcd(10));
        for (t = 11; t < 14; t++) cycle(0, 0, 0, bcd(t));
        cycle(0, 1, 0, bcd(14));
        cycle(0, 0, 0, bcd(15));
        cycle(0, 1, 0, bcd(16));
        cycle(0, 0, 0, bcd(17));

        cycle(0, 0, 1, bcd(0));
        for (t = 1; t <= 5; t++) cycle(1, 0, 0, bcd(t));
        for (int k = 0; k < 6; k++) cycle(0, 1, 0, bcd(20 + k));
        cycle(1, 0, 0, bcd(30));

        cycle(0, 0, 1, bcd(0));
        for (t = 1; t <= 3; t++) cycle(1, 0, 0, bcd(t));
        cycle(0, 1, 0, bcd(4));
        cycle(0, 1, 0, bcd(5));
        cycle(1, 1, 1, bcd(6));
        chk("clr_cnt", 32'(d6), 32'h0);

        cycle(1, 1, 0, bcd(7));
        chk("lv_sel", 32'(d7), 32'h0);
        cycle(0, 1, 0, bcd(8));
        chk("lv_sel2", 32'(d7), 32'h1);

        cycle(1, 0, 0, bcd(9));
        cycle(1, 0, 0, bcd(10));
        cycle(0, 1, 0, bcd(11));
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_disp", {d7, d6, d5, d4, d3, d2, d1, d0}, 32'h0);
        chk("arst_flags", {30'h0, full, ovf}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        cycle(0, 0, 0, 24'h000042);
        cycle(0, 1, 0, 24'h000043);

        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 24) == 0), rand_bcd());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lap_capture_mux.md
LAP_CAPTURE_MUX -- requirements
Module: lap_capture_mux

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of lap entries stored (legal 2..7).
REQ-002 SHALL have port clk  input  1  single system clock (100 MHz), all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports Q0..Q5  input  4 each  live BCD time digits from the watch core, Q0 least significant.
REQ-005 SHALL have port lap  input  1  debounced single-cycle pulse, capture current time.
REQ-006 SHALL have port view  input  1  debounced single-cycle pulse, advance display selection.
REQ-007 SHALL have port clr  input  1  single-cycle pulse, empty lap buffer.
REQ-008 SHALL have ports D0..D7  output  4 each  registered BCD digits to the 8-digit display driver.
REQ-009 SHALL have port full  output  1  registered, high when stored count equals DEPTH.
REQ-010 SHALL have port ovf  output  1  registered sticky flag, lap pulse arrived while full.

Function
REQ-011 SHALL hold DEPTH entries of 24 bits ({Q5..Q0}) in a circular buffer with write pointer wp, read base rp, count cnt (0..DEPTH).
REQ-012 SHALL, on a clk edge with lap=1 and cnt<DEPTH, store {Q5..Q0} sampled that edge at wp, wp<=wp+1 mod DEPTH, cnt<=cnt+1.
REQ-013 SHALL keep selector sel in 0..cnt: sel=0 LIVE mode, sel=k displays k-th stored lap, k=1 oldest.
REQ-014 SHALL, on view=1, set sel<=sel+1 if sel<cnt, else sel<=0 (wrap to LIVE); cnt used is the pre-edge value.
REQ-015 SHALL in LIVE drive D0..D5 <= Q0..Q5 with one clk latency, D6 <= cnt, D7 <= 0.
REQ-016 SHALL in lap mode sel=k drive D0..D5 from entry (rp+k-1) mod DEPTH, D6 <= cnt, D7 <= k; frozen regardless of Q changes.
REQ-017 SHALL, on clr=1, set cnt<=0, wp<=0, rp<=0, sel<=0, ovf<=0; clr has priority over lap and view in the same cycle.
REQ-018 SHALL, on lap and view in the same cycle (no clr), perform both: capture per REQ-012 and advance sel per REQ-014.
REQ-019 SHALL, on lap=1 with cnt=DEPTH, discard the capture (configuration dependent, REQ-025/026) and set ovf<=1.
REQ-020 SHALL drive full<=1 in the cycle after cnt reaches DEPTH and 0 after clr.
REQ-021 SHALL treat lap/view/clr held high multiple cycles as one event per cycle (no internal edge detect).

Reset
REQ-022 SHALL on rstn=0 asynchronously clear cnt, wp, rp, sel, ovf, full, D0..D7 to 0; buffer contents need not be cleared.
REQ-023 SHALL, when reset asserts mid-operation, abandon any capture in that cycle; after release block is in LIVE with cnt=0.
REQ-024 SHALL resume normal operation on the first rising clk edge after rstn deasserts.

Configuration
REQ-025 SHALL, with macro LAP_OVERWRITE_EN defined, on lap at cnt=DEPTH overwrite the oldest entry at wp, advance wp and rp by 1 mod DEPTH, keep cnt=DEPTH, set ovf<=1; a displayed sel=k then shows the new k-th oldest.
REQ-026 SHALL, without LAP_OVERWRITE_EN, drop the lap at cnt=DEPTH, leave wp/rp/buffer unchanged, set ovf<=1.

Verification
REQ-027 Reset, Q=12:34:56 (Q5..Q0=1,2,3,4,5,6) -> one cycle later D5..D0=1,2,3,4,5,6, D6=0, D7=0, full=0, ovf=0.
REQ-028 lap at 00:00:05, lap at 00:00:09, view, Q keeps counting -> D0=5, D7=1, D6=2 frozen; view -> D0=9, D7=2; view -> LIVE, D7=0.
REQ-029 Five laps at times 1..5 with DEPTH=4, macro undefined -> full=1, ovf=1, laps 1..4 show 1,2,3,4; with LAP_OVERWRITE_EN -> laps show 2,3,4,5.
REQ-030 clr, lap, view in same cycle with cnt=3, sel=2 -> next cycle cnt=0, sel=0 LIVE, ovf=0, full=0, D6=0.
REQ-031 lap and view same cycle with cnt=0, sel=0 -> cnt=1, sel=0 (pre-edge cnt=0 wraps) stays LIVE; next view -> sel=1.
REQ-032 rstn pulsed low while sel=2, cnt=3 -> D0..D7=0 immediately, LIVE with cnt=0 after release.
